// File: rtl/frame_expand_pkg.sv
// -----------------------------------------------------------------------------
// frame_expand_pkg
//   Shared types and helpers for the frame_expand FFT-input preprocessor.
//   - fe_state_t : framing FSM state (idle until the first sync, then run)
//   - idx_w()    : width of the in-frame sample index for a given frame length
// -----------------------------------------------------------------------------
package frame_expand_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fe_state_t;

   // Index width for an n-point frame; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/frame_peak_track.sv
// -----------------------------------------------------------------------------
// frame_peak_track
//   Tracks the largest sample magnitude within a frame and publishes it at the
//   last sample of the frame. The magnitude of the most negative code
//   saturates to the largest positive code, so the result always fits W_IN bits.
//   A frame that is abandoned by a resync never reaches its eop sample, so it
//   never produces a pulse; its partial maximum is discarded at the next sop.
//
// Ports
//   clk, rstn  : clock, asynchronous active-low reset
//   vld        : sample accepted this cycle
//   sop, eop   : accepted sample is index 0 / index N_FFT-1 of its frame
//   data       : signed sample
//   peak       : max |sample| of the last completed frame
//   peak_vld   : one-cycle pulse when peak is updated (aligned with o_eop)
// -----------------------------------------------------------------------------
module frame_peak_track #(
   parameter int W_IN = 16
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            vld,
   input  logic            sop,
   input  logic            eop,
   input  logic [W_IN-1:0] data,
   output logic [W_IN-1:0] peak,
   output logic            peak_vld
);

   localparam logic [W_IN-1:0] MOST_NEG = {1'b1, {(W_IN-1){1'b0}}};
   localparam logic [W_IN-1:0] MOST_POS = {1'b0, {(W_IN-1){1'b1}}};

   logic [W_IN-1:0] run_max;
   logic [W_IN-1:0] mag;
   logic [W_IN-1:0] base;
   logic [W_IN-1:0] cur_max;

   always_comb begin
      mag = data;
      if (data == MOST_NEG) begin
         mag = MOST_POS;
      end else if (data[W_IN-1]) begin
         mag = ~data + 1'b1;
      end
      // The sop sample restarts the running maximum.
      base    = sop ? '0 : run_max;
      // Magnitudes never exceed MOST_POS, so an unsigned compare is exact.
      cur_max = (mag > base) ? mag : base;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_max  <= '0;
         peak     <= '0;
         peak_vld <= 1'b0;
      end else begin
         peak_vld <= vld && eop;
         if (vld) begin
            run_max <= cur_max;
         end
         if (vld && eop) begin
            peak <= cur_max;
         end
      end
   end

endmodule

// File: rtl/frame_expand.sv
// -----------------------------------------------------------------------------
// frame_expand
//   FFT-input preprocessor. Each accepted signed W_IN sample is placed in a
//   W_OUT word with GUARD sign-copy headroom bits above it and zero fill below
//   it (exact, no rounding), one cycle after it arrives. Samples are grouped
//   into N_FFT-point frames marked with o_sop / o_eop.
//
//   Handshake: i_vld qualifies i_data for one cycle; there is no backpressure.
//   o_vld qualifies o_data, o_sop and o_eop; o_data holds its last value while
//   o_vld is low.
//
//   Framing: after reset all samples are discarded until the first i_sync.
//   i_sync (in either state) makes the sample of the same cycle, or else the
//   next accepted one, frame index 0; the abandoned partial frame gets no eop.
//
//   Optional feature macro FRAME_PEAK_EN: adds o_peak / o_peak_vld, the
//   saturated max |sample| of each completed frame (see frame_peak_track).
//
// Ports
//   clk, rstn   : clock, asynchronous active-low reset
//   i_sync      : frame realign request
//   i_data      : input sample (signed W_IN)
//   i_vld       : i_data valid
//   o_data      : expanded sample (W_OUT)
//   o_vld       : o_data valid
//   o_sop/o_eop : frame index 0 / N_FFT-1, qualified by o_vld
//   o_peak      : (FRAME_PEAK_EN) peak magnitude of last completed frame
//   o_peak_vld  : (FRAME_PEAK_EN) one-cycle pulse with o_eop
//   dbg_state   : current framing FSM state
//
//   W_OUT must be at least W_IN+GUARD; N_FFT must be a power of two >= 4.
// -----------------------------------------------------------------------------
module frame_expand
   import frame_expand_pkg::*;
#(
   parameter int W_IN  = 16,
   parameter int W_OUT = 32,
   parameter int GUARD = 4,
   parameter int N_FFT = 1024
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_sync,
   input  logic [W_IN-1:0]  i_data,
   input  logic             i_vld,
   output logic [W_OUT-1:0] o_data,
   output logic             o_vld,
   output logic             o_sop,
   output logic             o_eop,
`ifdef FRAME_PEAK_EN
   output logic [W_IN-1:0]  o_peak,
   output logic             o_peak_vld,
`endif
   output fe_state_t        dbg_state
);

   localparam int               IDX_W    = idx_w(N_FFT);
   localparam int               PAD      = W_OUT - W_IN - GUARD;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FFT - 1);

   fe_state_t        state;
   logic [IDX_W-1:0] idx;       // index the next accepted sample will take
   logic             accept;
   logic [IDX_W-1:0] smp_idx;   // index of the sample on i_data this cycle
   logic             is_first;
   logic             is_last;
   logic [W_OUT-1:0] expanded;

   always_comb begin
      // In IDLE the sync cycle itself already counts as running.
      accept   = i_vld && ((state == ST_RUN) || i_sync);
      // Sync overrides the counter, including at index N_FFT-1.
      smp_idx  = i_sync ? '0 : idx;
      is_first = (smp_idx == '0);
      is_last  = (smp_idx == IDX_LAST);
      // Sign-extend to the full word, then shift the zero fill in from below;
      // the shift drops the surplus sign copies, leaving exactly GUARD of them.
      expanded = W_OUT'($signed(i_data)) << PAD;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= ST_IDLE;
         idx    <= '0;
         o_data <= '0;
         o_vld  <= 1'b0;
         o_sop  <= 1'b0;
         o_eop  <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && i_sync) begin
            state <= ST_RUN;
         end

         if (accept) begin
            idx <= is_last ? '0 : smp_idx + 1'b1;
         end else if (i_sync) begin
            idx <= '0;
         end

         o_vld <= accept;
         o_sop <= accept && is_first;
         o_eop <= accept && is_last;
         if (accept) begin
            o_data <= expanded;
         end
      end
   end

   assign dbg_state = state;

`ifdef FRAME_PEAK_EN
   frame_peak_track #(
      .W_IN (W_IN)
   ) u_peak (
      .clk      (clk),
      .rstn     (rstn),
      .vld      (accept),
      .sop      (is_first),
      .eop      (is_last),
      .data     (i_data),
      .peak     (o_peak),
      .peak_vld (o_peak_vld)
   );
`endif

endmodule

// File: tb/tb_frame_expand.sv
// -----------------------------------------------------------------------------
// tb_frame_expand
//   Directed bench for frame_expand with N_FFT=8, W_IN=16, W_OUT=32, GUARD=4.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, one cycle after the inputs that produced them.
//   Define FRAME_PEAK_EN for both the RTL and this file to cover the peak port.
// -----------------------------------------------------------------------------
module tb_frame_expand;
   import frame_expand_pkg::*;

   localparam int W_IN  = 16;
   localparam int W_OUT = 32;
   localparam int GUARD = 4;
   localparam int N_FFT = 8;

   logic             clk;
   logic             rstn;
   logic             i_sync;
   logic [W_IN-1:0]  i_data;
   logic             i_vld;
   logic [W_OUT-1:0] o_data;
   logic             o_vld;
   logic             o_sop;
   logic             o_eop;
   fe_state_t        dbg_state;
`ifdef FRAME_PEAK_EN
   logic [W_IN-1:0]  o_peak;
   logic             o_peak_vld;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   frame_expand #(
      .W_IN  (W_IN),
      .W_OUT (W_OUT),
      .GUARD (GUARD),
      .N_FFT (N_FFT)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_sync     (i_sync),
      .i_data     (i_data),
      .i_vld      (i_vld),
      .o_data     (o_data),
      .o_vld      (o_vld),
      .o_sop      (o_sop),
      .o_eop      (o_eop),
`ifdef FRAME_PEAK_EN
      .o_peak     (o_peak),
      .o_peak_vld (o_peak_vld),
`endif
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver ----------------
   // Apply one cycle of inputs; return 1 unit after the edge that captured them.
   task automatic drive(input logic sync, input logic vld, input logic [W_IN-1:0] d);
      i_sync = sync;
      i_vld  = vld;
      i_data = d;
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn   = 1'b0;
      i_sync = 1'b0;
      i_vld  = 1'b0;
      i_data = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (o_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", o_vld); else n_pass++;
      n_checks++; if (o_sop !== 1'b0 || o_eop !== 1'b0) $display("FAIL reset_sop_eop: got %b%b want 00", o_sop, o_eop); else n_pass++;
      n_checks++; if (o_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", o_data); else n_pass++;
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want IDLE", dbg_state); else n_pass++;
`ifdef FRAME_PEAK_EN
      n_checks++; if (o_peak !== 16'h0 || o_peak_vld !== 1'b0) $display("FAIL reset_peak: got %h/%b want 0000/0", o_peak, o_peak_vld); else n_pass++;
`endif
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_idle_discard();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 16'(16'h0100 + i));
         n_checks++; if (o_vld !== 1'b0) $display("FAIL idle_vld[%0d]: got %b want 0", i, o_vld); else n_pass++;
      end
      drive(1'b1, 1'b1, 16'h0001);
      n_checks++; if (o_vld !== 1'b1) $display("FAIL first_sync_vld: got %b want 1", o_vld); else n_pass++;
      n_checks++; if (o_sop !== 1'b1) $display("FAIL first_sync_sop: got %b want 1", o_sop); else n_pass++;
      n_checks++; if (o_data !== 32'h00001000) $display("FAIL first_sync_data: got %h want 00001000", o_data); else n_pass++;
      n_checks++; if (dbg_state !== ST_RUN) $display("FAIL first_sync_state: got %0d want RUN", dbg_state); else n_pass++;
   endtask

   task automatic test_expand();
      drive(1'b0, 1'b1, 16'h8001);
      n_checks++; if (o_data !== 32'hF8001000) $display("FAIL expand_8001: got %h want F8001000", o_data); else n_pass++;
      n_checks++; if (o_sop !== 1'b0) $display("FAIL expand_sop: got %b want 0", o_sop); else n_pass++;
      drive(1'b0, 1'b1, 16'h7FFF);
      n_checks++; if (o_data !== 32'h07FFF000) $display("FAIL expand_7fff: got %h want 07FFF000", o_data); else n_pass++;
      drive(1'b0, 1'b1, 16'hFFFF);
      n_checks++; if (o_data !== 32'hFFFFF000) $display("FAIL expand_ffff: got %h want FFFFF000", o_data); else n_pass++;
      drive(1'b0, 1'b0, 16'h1234);
      n_checks++; if (o_vld !== 1'b0) $display("FAIL hold_vld: got %b want 0", o_vld); else n_pass++;
      n_checks++; if (o_data !== 32'hFFFFF000) $display("FAIL hold_data: got %h want FFFFF000", o_data); else n_pass++;
   endtask

   task automatic test_frame_count();
      int n     = 0;
      int cyc   = 0;
      int n_sop = 0;
      int n_eop = 0;
      logic [W_IN-1:0]  d;
      logic [W_OUT-1:0] exp_d;
      // Realign without a sample: the next accepted sample is index 0.
      drive(1'b1, 1'b0, 16'h0000);
      while (n < 20 && cyc < 200) begin
         cyc++;
         if ($urandom_range(0, 2) != 0) begin
            d     = 16'(n * 3 + 1);
            exp_d = {4'h0, d, 12'h000};
            drive(1'b0, 1'b1, d);
            if (o_sop === 1'b1) n_sop++;
            if (o_eop === 1'b1) n_eop++;
            n_checks++; if (o_vld !== 1'b1) $display("FAIL frame_vld[%0d]: got %b want 1", n, o_vld); else n_pass++;
            n_checks++; if (o_sop !== ((n % 8) == 0)) $display("FAIL frame_sop[%0d]: got %b want %b", n, o_sop, (n % 8) == 0); else n_pass++;
            n_checks++; if (o_eop !== ((n % 8) == 7)) $display("FAIL frame_eop[%0d]: got %b want %b", n, o_eop, (n % 8) == 7); else n_pass++;
            n_checks++; if (o_data !== exp_d) $display("FAIL frame_data[%0d]: got %h want %h", n, o_data, exp_d); else n_pass++;
            n++;
         end else begin
            drive(1'b0, 1'b0, 16'hDEAD);
            n_checks++; if (o_vld !== 1'b0) $display("FAIL gap_vld: got %b want 0", o_vld); else n_pass++;
         end
      end
      n_checks++; if (n != 20) $display("FAIL frame_budget: got %0d samples want 20", n); else n_pass++;
      n_checks++; if (n_sop != 3 || n_eop != 2) $display("FAIL frame_marks: got sop=%0d eop=%0d want sop=3 eop=2", n_sop, n_eop); else n_pass++;
   endtask

   task automatic test_sync_mid();
      // Counter sits at index 4 here; a sync with a sample restarts the frame.
      drive(1'b1, 1'b1, 16'h00A0);
      n_checks++; if (o_sop !== 1'b1) $display("FAIL resync_sop: got %b want 1", o_sop); else n_pass++;
      for (int i = 1; i < 5; i++) drive(1'b0, 1'b1, 16'(i));
      // Sample 5 of the frame arrives with sync: new frame, no eop for the old one.
      drive(1'b1, 1'b1, 16'h0055);
      n_checks++; if (o_sop !== 1'b1 || o_eop !== 1'b0) $display("FAIL mid_sync: got sop=%b eop=%b want sop=1 eop=0", o_sop, o_eop); else n_pass++;
      for (int i = 1; i < 8; i++) begin
         drive(1'b0, 1'b1, 16'(i));
         n_checks++; if (o_eop !== (i == 7) || o_sop !== 1'b0) $display("FAIL after_sync[%0d]: got sop=%b eop=%b want sop=0 eop=%b", i, o_sop, o_eop, i == 7); else n_pass++;
      end
      // Walk to index 7, then collide sync with the last index.
      for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 16'(i));
      drive(1'b1, 1'b1, 16'h0077);
      n_checks++; if (o_sop !== 1'b1 || o_eop !== 1'b0) $display("FAIL sync_last: got sop=%b eop=%b want sop=1 eop=0", o_sop, o_eop); else n_pass++;
`ifdef FRAME_PEAK_EN
      n_checks++; if (o_peak_vld !== 1'b0) $display("FAIL abandoned_peak: got %b want 0", o_peak_vld); else n_pass++;
`endif
      // Sync with no sample: the next accepted sample is index 0.
      drive(1'b1, 1'b0, 16'h0000);
      n_checks++; if (o_vld !== 1'b0) $display("FAIL sync_novld: got %b want 0", o_vld); else n_pass++;
      drive(1'b0, 1'b1, 16'h0011);
      n_checks++; if (o_sop !== 1'b1) $display("FAIL sync_then_sample: got %b want 1", o_sop); else n_pass++;
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 16'h4321);
      drive(1'b0, 1'b1, 16'h4322);
      rstn = 1'b0;
      #1;
      n_checks++; if (o_vld !== 1'b0 || o_data !== 32'h0) $display("FAIL async_rst: got vld=%b data=%h want 0/00000000", o_vld, o_data); else n_pass++;
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL async_rst_state: got %0d want IDLE", dbg_state); else n_pass++;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 16'h5555);
         n_checks++; if (o_vld !== 1'b0) $display("FAIL post_rst_idle[%0d]: got %b want 0", i, o_vld); else n_pass++;
      end
      drive(1'b1, 1'b1, 16'h1234);
      n_checks++; if (o_vld !== 1'b1 || o_sop !== 1'b1) $display("FAIL post_rst_sync: got vld=%b sop=%b want 1/1", o_vld, o_sop); else n_pass++;
      n_checks++; if (o_data !== 32'h01234000) $display("FAIL post_rst_data: got %h want 01234000", o_data); else n_pass++;
   endtask

`ifdef FRAME_PEAK_EN
   task automatic test_peak();
      logic [W_IN-1:0] fa [8] = '{16'd3, 16'hFFF7, 16'd4, 16'd0, 16'h8000, 16'd1, 16'd2, 16'd5};
      logic [W_IN-1:0] fb [8] = '{16'd1, 16'hFFFE, 16'd100, 16'hFF9C, 16'd7, 16'hFF9B, 16'd0, 16'd50};
      drive(1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, fa[i]);
         n_checks++; if (o_peak_vld !== (i == 7)) $display("FAIL peak_a_vld[%0d]: got %b want %b", i, o_peak_vld, i == 7); else n_pass++;
      end
      n_checks++; if (o_peak !== 16'h7FFF || o_eop !== 1'b1) $display("FAIL peak_a: got %h eop=%b want 7fff eop=1", o_peak, o_eop); else n_pass++;
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, fb[i]);
      n_checks++; if (o_peak !== 16'd101 || o_peak_vld !== 1'b1) $display("FAIL peak_b: got %h/%b want 0065/1", o_peak, o_peak_vld); else n_pass++;
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_idle_discard();
      test_expand();
      test_frame_count();
      test_sync_mid();
      test_reset_mid();
`ifdef FRAME_PEAK_EN
      test_peak();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
